// File: rtl/pipe_ctl_pkg.sv
// pipe_ctl_pkg
// Shared definitions for the pipeline interlock sequencer.
//   - State encodings RUN / MDWAIT / HALT and the state enum built on them
//   - Default width of the stall-cycle counter
package pipe_ctl_pkg;

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] MDWAIT = 2'd1;
  localparam logic [1:0] HALT   = 2'd2;

  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_RUN    = RUN,
    ST_MDWAIT = MDWAIT,
    ST_HALT   = HALT
  } state_t;

endpackage

// File: rtl/pipe_stall_ctl_if.sv
// pipe_stall_ctl_if
// Bundles the hazard/request inputs and the interlock outputs of the
// pipeline stall controller.
//   Inputs to the controller : nostall, imem_rdy, md_start, md_done,
//                              dbg_halt_req, cnt_clr
//   Outputs of the controller: wpcir, id_bubble, md_go, halted, stall_cnt
//   Modports: master = pipeline side driving requests, slave = controller
interface pipe_stall_ctl_if #(
  parameter int CNT_W = pipe_ctl_pkg::CNT_W_DEFAULT
);

  logic             nostall;
  logic             imem_rdy;
  logic             md_start;
  logic             md_done;
  logic             dbg_halt_req;
  logic             cnt_clr;
  logic             wpcir;
  logic             id_bubble;
  logic             md_go;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output nostall, imem_rdy, md_start, md_done, dbg_halt_req, cnt_clr,
    input  wpcir, id_bubble, md_go, halted, stall_cnt
  );

  modport slave (
    input  nostall, imem_rdy, md_start, md_done, dbg_halt_req, cnt_clr,
    output wpcir, id_bubble, md_go, halted, stall_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// sat_counter
// Saturating up-counter with synchronous clear.
//   clk   : clock
//   clrn  : asynchronous active-low reset (count -> 0)
//   clr   : synchronous clear, wins over inc
//   inc   : count up by one unless already all-ones
//   count : current value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Clear beats increment; once all-ones the count sticks until cleared.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stall_ctl.sv
// pipe_stall_ctl
// Central interlock sequencer for the five-stage pipeline. Merges load-use
// stalls, instruction-memory wait, a multi-cycle mul/div unit and a debug
// halt into one PC/IF-ID write enable (wpcir) and one ID/EX bubble control.
//   clk  : pipeline clock
//   clrn : asynchronous active-low reset
//   bus  : slave side of pipe_stall_ctl_if
//          in : nostall, imem_rdy, md_start, md_done, dbg_halt_req, cnt_clr
//          out: wpcir, id_bubble, md_go (comb), halted, stall_cnt (registered)
module pipe_stall_ctl
  import pipe_ctl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   clrn,
  pipe_stall_ctl_if.slave        bus
);

  state_t           state;
  state_t           state_nxt;
  logic             halted_q;
  logic             wpcir_c;
  logic             md_go_c;
  logic [CNT_W-1:0] stall_cnt;

  // State register; halted mirrors "in HALT" one edge behind the decision.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state    <= ST_RUN;
      halted_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      halted_q <= (state_nxt == ST_HALT);
    end
  end

  // Next-state and interlock outputs. RUN checks causes in priority order so
  // a mul/div start or halt is only accepted once fetch and load-use are clear.
  always_comb begin
    state_nxt = state;
    wpcir_c   = 1'b1;
    md_go_c   = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (!bus.imem_rdy) begin
          wpcir_c = 1'b0;
        end else if (!bus.nostall) begin
          wpcir_c = 1'b0;
        end else if (bus.md_start) begin
          // mul/div instruction stays in ID until md_done lets it issue
          md_go_c   = 1'b1;
          wpcir_c   = 1'b0;
          state_nxt = ST_MDWAIT;
        end else if (bus.dbg_halt_req) begin
          wpcir_c   = 1'b0;
          state_nxt = ST_HALT;
        end
      end
      ST_MDWAIT: begin
        if (bus.md_done) begin
          state_nxt = ST_RUN;
        end else begin
          wpcir_c = 1'b0;
        end
      end
      ST_HALT: begin
        // the exit cycle still holds; fetch resumes from RUN next cycle
        wpcir_c = 1'b0;
        if (!bus.dbg_halt_req) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
    // While in reset the outputs look like an idle RUN cycle with no start.
    if (!clrn) begin
      wpcir_c = 1'b1;
      md_go_c = 1'b0;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .clrn  (clrn),
    .clr   (bus.cnt_clr),
    .inc   (~wpcir_c),
    .count (stall_cnt)
  );

  assign bus.wpcir     = wpcir_c;
  assign bus.id_bubble = ~wpcir_c;
  assign bus.md_go     = md_go_c;
  assign bus.halted    = halted_q;
  assign bus.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_pipe_stall_ctl.sv
// tb_pipe_stall_ctl
// Directed bench for pipe_stall_ctl with a 4-bit stall counter. A vector
// table walks load-use, mul/div, halt and priority cases cycle by cycle;
// hand sequences cover counter saturation/clear and reset mid-MDWAIT/HALT.
module tb_pipe_stall_ctl;

  localparam int CW = 4;

  logic clk;
  logic clrn;
  int   checks;
  int   errors;

  pipe_stall_ctl_if #(.CNT_W(CW)) bus ();

  pipe_stall_ctl #(
    .CNT_W (CW)
  ) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  // in  = {nostall, imem_rdy, md_start, md_done, dbg_halt_req, cnt_clr}
  // out = {wpcir, id_bubble, md_go, halted}
  typedef struct {
    logic [5:0]    in;
    logic [3:0]    out;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vq[$];

  // free-running clock, posedge at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [5:0] in, input logic [3:0] out,
                              input logic [CW-1:0] cnt);
    vec_t v;
    v.in  = in;
    v.out = out;
    v.cnt = cnt;
    return v;
  endfunction

  task automatic applyStimulus(input logic [5:0] in);
    bus.nostall      = in[5];
    bus.imem_rdy     = in[4];
    bus.md_start     = in[3];
    bus.md_done      = in[2];
    bus.dbg_halt_req = in[1];
    bus.cnt_clr      = in[0];
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [3:0] out,
                          input logic [CW-1:0] cnt);
    checkOutput({tag, "_wpcir"},     16'(bus.wpcir),     16'(out[3]));
    checkOutput({tag, "_id_bubble"}, 16'(bus.id_bubble), 16'(out[2]));
    checkOutput({tag, "_md_go"},     16'(bus.md_go),     16'(out[1]));
    checkOutput({tag, "_halted"},    16'(bus.halted),    16'(out[0]));
    checkOutput({tag, "_stall_cnt"}, 16'(bus.stall_cnt), 16'(cnt));
  endtask

  // one cycle: drive just after the edge, check mid-cycle
  task automatic cycle(input logic [5:0] in);
    @(posedge clk);
    #1;
    applyStimulus(in);
    #3;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vq.push_back(mk(6'b110000, 4'b1000, 4'd0));  // idle
    vq.push_back(mk(6'b010000, 4'b0100, 4'd0));  // load-use
    vq.push_back(mk(6'b110000, 4'b1000, 4'd1));
    vq.push_back(mk(6'b110100, 4'b1000, 4'd1));  // stray md_done ignored
    vq.push_back(mk(6'b101000, 4'b0100, 4'd1));  // imem wait beats md_start
    vq.push_back(mk(6'b111000, 4'b0110, 4'd2));  // md_go
    vq.push_back(mk(6'b000010, 4'b0100, 4'd3));  // MDWAIT ignores others
    vq.push_back(mk(6'b110000, 4'b0100, 4'd4));
    vq.push_back(mk(6'b110000, 4'b0100, 4'd5));
    vq.push_back(mk(6'b110100, 4'b1000, 4'd6));  // md_done issues
    vq.push_back(mk(6'b110000, 4'b1000, 4'd6));
    vq.push_back(mk(6'b110001, 4'b1000, 4'd6));  // clear
    vq.push_back(mk(6'b110000, 4'b1000, 4'd0));
    vq.push_back(mk(6'b110010, 4'b0100, 4'd0));  // halt request
    vq.push_back(mk(6'b110010, 4'b0101, 4'd1));
    vq.push_back(mk(6'b110010, 4'b0101, 4'd2));
    vq.push_back(mk(6'b110000, 4'b0101, 4'd3));  // release, still holds
    vq.push_back(mk(6'b110000, 4'b1000, 4'd4));
    vq.push_back(mk(6'b111010, 4'b0110, 4'd4));  // md_start + halt: mul/div
    vq.push_back(mk(6'b110110, 4'b1000, 4'd5));  // done in first MDWAIT cycle
    vq.push_back(mk(6'b110010, 4'b0100, 4'd5));  // halt taken after issue
    vq.push_back(mk(6'b111000, 4'b0101, 4'd6));  // md_start ignored in HALT
    vq.push_back(mk(6'b110000, 4'b1000, 4'd7));
    vq.push_back(mk(6'b011000, 4'b0100, 4'd7));  // load-use beats md_start
    vq.push_back(mk(6'b110000, 4'b1000, 4'd8));

    // reset with aggressive inputs: outputs must look like idle RUN
    clrn = 1'b0;
    applyStimulus(6'b101010);
    #7;
    checkAll("reset", 4'b1000, 4'd0);
    #10;
    applyStimulus(6'b110000);
    #5;
    clrn = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      cycle(vq[i].in);
      checkAll($sformatf("v%0d", i), vq[i].out, vq[i].cnt);
    end

    // counter saturation and clear while still stalled
    cycle(6'b110001);
    repeat (20) cycle(6'b010000);
    cycle(6'b010001);
    checkOutput("sat_cnt", 16'(bus.stall_cnt), 16'd15);
    checkOutput("sat_wpcir", 16'(bus.wpcir), 16'd0);
    cycle(6'b010000);
    checkOutput("clr_cnt", 16'(bus.stall_cnt), 16'd0);
    cycle(6'b110000);
    checkOutput("after_clr_cnt", 16'(bus.stall_cnt), 16'd1);

    // reset in the middle of MDWAIT
    cycle(6'b111000);
    checkOutput("rst_md_go", 16'(bus.md_go), 16'd1);
    cycle(6'b111000);
    checkOutput("rst_mdwait_wpcir", 16'(bus.wpcir), 16'd0);
    #1;
    clrn = 1'b0;
    #1;
    checkAll("rst_mdwait", 4'b1000, 4'd0);
    @(posedge clk);
    #2;
    applyStimulus(6'b110000);
    clrn = 1'b1;
    #2;
    checkOutput("post_rst_mdwait_wpcir", 16'(bus.wpcir), 16'd1);

    // reset in the middle of HALT
    cycle(6'b110010);
    cycle(6'b110010);
    checkOutput("rst_halt_halted", 16'(bus.halted), 16'd1);
    #1;
    clrn = 1'b0;
    #1;
    checkAll("rst_halt", 4'b1000, 4'd0);
    @(posedge clk);
    #2;
    applyStimulus(6'b110000);
    clrn = 1'b1;
    #2;
    checkOutput("post_rst_halt_wpcir", 16'(bus.wpcir), 16'd1);
    cycle(6'b110000);
    checkOutput("post_rst_halt_halted", 16'(bus.halted), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
